seq_right_shifter: RTL



---
 rtl/alu_pkg.sv | 16 +
 rtl/right_shift_stage.sv | 28 ++
 rtl/seq_right_shifter.sv | 117 +++++++++++
 3 files changed

// File: rtl/alu_pkg.sv
// Shared ALU definitions used by the sequential right shifter.
//   WIDTH   : datapath width in bits
//   SHAMT_W : shift-amount width (log2 of WIDTH), also the number of shift stages
//   state_e : shifter FSM state encoding
package alu_pkg;

    localparam int unsigned WIDTH   = 32;
    localparam int unsigned SHAMT_W = 5;

    typedef enum logic [1:0] {
        StIdle  = 2'd0,
        StShift = 2'd1,
        StDone  = 2'd2
    } state_e;

endpackage

// File: rtl/right_shift_stage.sv
// One binary stage of a right shifter: shifts a right by 2^k, filling the vacated
// upper bits with fill.
// Ports:
//   a    : value to shift
//   fill : bit replicated into the vacated upper positions
//   k    : stage index, shift distance is 2^k
//   y    : shifted value
module right_shift_stage #(
    parameter int unsigned WIDTH   = 32,
    parameter int unsigned SHAMT_W = 5
) (
    input  logic [WIDTH-1:0]           a,
    input  logic                       fill,
    input  logic [$clog2(SHAMT_W)-1:0] k,
    output logic [WIDTH-1:0]           y
);

    logic [SHAMT_W-1:0] amt;
    logic [WIDTH-1:0]   fill_mask;

    always_comb begin
        amt       = SHAMT_W'(1) << k;
        // Ones in exactly the top 2^k positions.
        fill_mask = ~({WIDTH{1'b1}} >> amt);
        y         = (a >> amt) | ({WIDTH{fill}} & fill_mask);
    end

endmodule

// File: rtl/seq_right_shifter.sv
// Multi-cycle right shifter (SRL / SRA). One binary stage (1, 2, 4, 8, 16 bits) is
// resolved per clock, so every operation takes SHAMT_W shift cycles regardless of
// the shift amount. Operands enter and results leave over valid/ready handshakes.
// Ports:
//   clock, reset_n      : clock and asynchronous active-low reset
//   in_valid / in_ready : operand handshake (in_ready high only in IDLE)
//   data_in, shamt      : value and shift amount, captured at accept
//   arith               : 1 = sign fill, 0 = zero fill; captured at accept
//   out_valid/out_ready : result handshake (out_valid high only in DONE)
//   result              : last completed result, held until the next one completes
//   busy                : high while an operation is in flight (SHIFT or DONE)
module seq_right_shifter #(
    parameter int unsigned WIDTH   = alu_pkg::WIDTH,
    parameter int unsigned SHAMT_W = alu_pkg::SHAMT_W
) (
    input  logic               clock,
    input  logic               reset_n,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [WIDTH-1:0]   data_in,
    input  logic [SHAMT_W-1:0] shamt,
    input  logic               arith,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [WIDTH-1:0]   result,
    output logic               busy
);

    import alu_pkg::*;

    localparam int unsigned KW = $clog2(SHAMT_W);
    localparam logic [KW-1:0] KLast = KW'(SHAMT_W - 1);

    state_e             state_q, state_d;
    logic [KW-1:0]      k_q, k_d;
    logic [WIDTH-1:0]   work_q, work_d;
    logic [WIDTH-1:0]   res_q, res_d;
    logic [SHAMT_W-1:0] shamt_q, shamt_d;
    logic               fill_q, fill_d;
    logic [WIDTH-1:0]   stage_out;
    logic [WIDTH-1:0]   shifted;

    right_shift_stage #(
        .WIDTH   (WIDTH),
        .SHAMT_W (SHAMT_W)
    ) u_stage (
        .a    (work_q),
        .fill (fill_q),
        .k    (k_q),
        .y    (stage_out)
    );

    // Stage k only applies when the matching shift-amount bit is set.
    assign shifted = shamt_q[k_q] ? stage_out : work_q;

    always_comb begin
        state_d = state_q;
        k_d     = k_q;
        work_d  = work_q;
        res_d   = res_q;
        shamt_d = shamt_q;
        fill_d  = fill_q;
        case (state_q)
            StIdle: begin
                if (in_valid) begin
                    work_d  = data_in;
                    shamt_d = shamt;
                    fill_d  = arith & data_in[WIDTH-1];
                    k_d     = '0;
                    state_d = StShift;
                end
            end
            StShift: begin
                work_d = shifted;
                k_d    = k_q + 1'b1;
                if (k_q == KLast) begin
                    // Result register only moves on the final stage edge.
                    res_d   = shifted;
                    k_d     = '0;
                    state_d = StDone;
                end
            end
            StDone: begin
                if (out_ready) begin
                    state_d = StIdle;
                end
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= StIdle;
            k_q     <= '0;
            work_q  <= '0;
            res_q   <= '0;
            shamt_q <= '0;
            fill_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            k_q     <= k_d;
            work_q  <= work_d;
            res_q   <= res_d;
            shamt_q <= shamt_d;
            fill_q  <= fill_d;
        end
    end

    assign in_ready  = (state_q == StIdle);
    assign out_valid = (state_q == StDone);
    assign busy      = (state_q != StIdle);
    assign result    = res_q;

endmodule
